// File: rtl/multi_reg_wr_seq.sv
// ----------------------------------------------------------------------------
// multi_reg_wr_seq
//
// Write-register-address generator for LDM/STM/PUSH/POP style multi-register
// transfers. On start it latches a register list and walks it one register
// per accepted step, lowest index first. It can then run a single base
// register (Rn) writeback cycle. While idle, the register-file write address
// is passed through from one of the single-op address candidates.
//
// Optional feature (compile-time macro):
//   WB_SUPPRESS_IN_LIST_EN - when defined, a load whose list contains Rn
//                            skips the writeback phase so that the loaded
//                            value is the one left in Rn.
//
// Parameters:
//   NREG  register-list width, bit k selects register k
//   AW    register address width (2**AW >= NREG)
//   CW    reg_count width (>= clog2(NREG+1))
//
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   start           in   launch a sequence (sampled only when idle)
//   is_load         in   1 = registers are written (LDM/POP)
//   wb_en           in   run Rn writeback after the list
//   reg_list        in   register list
//   rn              in   base register
//   step            in   current transfer accepted
//   w_reg_addr_src  in   pass-through select: 0=d 1=t 3=n, others give 0
//   addr_d/t/n      in   candidate single-op write addresses
//   w_reg_addr      out  register-file write address (combinational)
//   w_reg_en_multi  out  write enable from the sequencer
//   xfer_valid      out  a list transfer is presented
//   xfer_addr       out  register index of the current transfer
//   xfer_last       out  current transfer is the final list entry
//   wb_valid        out  writeback cycle active
//   reg_count       out  popcount of the latched list
//   busy            out  sequence in progress
//   done            out  one-cycle pulse on return to idle
// ----------------------------------------------------------------------------
module multi_reg_wr_seq #(
    parameter int NREG = 8,
    parameter int AW   = 4,
    parameter int CW   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_load,
    input  logic            wb_en,
    input  logic [NREG-1:0] reg_list,
    input  logic [AW-1:0]   rn,
    input  logic            step,
    input  logic [2:0]      w_reg_addr_src,
    input  logic [AW-1:0]   addr_d,
    input  logic [AW-1:0]   addr_t,
    input  logic [AW-1:0]   addr_n,
    output logic [AW-1:0]   w_reg_addr,
    output logic            w_reg_en_multi,
    output logic            xfer_valid,
    output logic [AW-1:0]   xfer_addr,
    output logic            xfer_last,
    output logic            wb_valid,
    output logic [CW-1:0]   reg_count,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_WB,
        S_DONE
    } state_t;

    state_t          state;
    logic [NREG-1:0] list_q;
    logic [AW-1:0]   rn_q;
    logic            is_load_q;
    logic            wb_do_q;

    logic [AW-1:0]   low_idx;
    logic [NREG-1:0] low_bit;
    logic            one_left;
    logic [CW-1:0]   start_count;
    logic            wb_take;

    // Priority encoder: the scan runs high to low so the lowest set bit
    // is the last one to overwrite the result.
    always_comb begin
        low_idx = '0;
        for (int k = NREG - 1; k >= 0; k--) begin
            if (list_q[k]) begin
                low_idx = AW'(k);
            end
        end
    end

    // Two's-complement trick isolates the lowest remaining bit; clearing it
    // leaves nothing exactly when a single entry remains.
    assign low_bit  = list_q & (~list_q + NREG'(1));
    assign one_left = ((list_q & (list_q - NREG'(1))) == '0);

    // Popcount of the incoming list, latched as reg_count at start.
    always_comb begin
        start_count = '0;
        for (int k = 0; k < NREG; k++) begin
            start_count = start_count + CW'(reg_list[k]);
        end
    end

`ifdef WB_SUPPRESS_IN_LIST_EN
    logic rn_in_list;

    // A load that also targets Rn keeps the loaded value, so the writeback
    // decision is made once at start from the incoming list.
    always_comb begin
        rn_in_list = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            if (rn == AW'(k)) begin
                rn_in_list = reg_list[k];
            end
        end
    end

    assign wb_take = wb_en & ~(is_load & rn_in_list);
`else
    assign wb_take = wb_en;
`endif

    // Sequencer: all status outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            list_q     <= '0;
            rn_q       <= '0;
            is_load_q  <= 1'b0;
            wb_do_q    <= 1'b0;
            reg_count  <= '0;
            xfer_valid <= 1'b0;
            wb_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        list_q    <= reg_list;
                        rn_q      <= rn;
                        is_load_q <= is_load;
                        wb_do_q   <= wb_take;
                        reg_count <= start_count;
                        busy      <= 1'b1;
                        if (|reg_list) begin
                            state      <= S_XFER;
                            xfer_valid <= 1'b1;
                        end else if (wb_take) begin
                            state    <= S_WB;
                            wb_valid <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_XFER: begin
                    if (step) begin
                        list_q <= list_q & ~low_bit;
                        if (one_left) begin
                            xfer_valid <= 1'b0;
                            if (wb_do_q) begin
                                state    <= S_WB;
                                wb_valid <= 1'b1;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                S_WB: begin
                    wb_valid <= 1'b0;
                    state    <= S_DONE;
                    done     <= 1'b1;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    xfer_valid <= 1'b0;
                    wb_valid   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    assign xfer_addr      = xfer_valid ? low_idx : '0;
    assign xfer_last      = xfer_valid & one_left;
    assign w_reg_en_multi = (xfer_valid & is_load_q & step) | wb_valid;

    // Write address: an active sequence owns the port, otherwise the
    // decoded single-op source is passed through.
    always_comb begin
        w_reg_addr = '0;
        if (xfer_valid) begin
            w_reg_addr = xfer_addr;
        end else if (wb_valid) begin
            w_reg_addr = rn_q;
        end else begin
            case (w_reg_addr_src)
                3'd0:    w_reg_addr = addr_d;
                3'd1:    w_reg_addr = addr_t;
                3'd3:    w_reg_addr = addr_n;
                default: w_reg_addr = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_reg_wr_seq.sv
// ----------------------------------------------------------------------------
// tb_multi_reg_wr_seq
//
// Self-checking bench for multi_reg_wr_seq. A queue-based model tracks the
// registers still to transfer and whether a writeback and done cycle are
// owed; a compare process checks every output on each falling edge. Directed
// scenarios add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_multi_reg_wr_seq;

    localparam int NREG = 8;
    localparam int AW   = 4;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            is_load = 1'b0;
    logic            wb_en = 1'b0;
    logic [NREG-1:0] reg_list = '0;
    logic [AW-1:0]   rn = '0;
    logic            step = 1'b0;
    logic [2:0]      w_reg_addr_src = '0;
    logic [AW-1:0]   addr_d = '0;
    logic [AW-1:0]   addr_t = '0;
    logic [AW-1:0]   addr_n = '0;
    logic [AW-1:0]   w_reg_addr;
    logic            w_reg_en_multi;
    logic            xfer_valid;
    logic [AW-1:0]   xfer_addr;
    logic            xfer_last;
    logic            wb_valid;
    logic [CW-1:0]   reg_count;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;

    multi_reg_wr_seq #(.NREG(NREG), .AW(AW), .CW(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .is_load        (is_load),
        .wb_en          (wb_en),
        .reg_list       (reg_list),
        .rn             (rn),
        .step           (step),
        .w_reg_addr_src (w_reg_addr_src),
        .addr_d         (addr_d),
        .addr_t         (addr_t),
        .addr_n         (addr_n),
        .w_reg_addr     (w_reg_addr),
        .w_reg_en_multi (w_reg_en_multi),
        .xfer_valid     (xfer_valid),
        .xfer_addr      (xfer_addr),
        .xfer_last      (xfer_last),
        .wb_valid       (wb_valid),
        .reg_count      (reg_count),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Single comparison point shared by the model checker and the literals.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model state: registers still owed, owed writeback, and whether a
    // sequence is running at all (its final cycle being the done pulse).
    int q[$];
    bit m_active  = 1'b0;
    bit m_wb_owed = 1'b0;
    bit m_is_load = 1'b0;
    int m_rn      = 0;
    int m_count   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_active  = 1'b0;
            m_wb_owed = 1'b0;
            m_is_load = 1'b0;
            m_rn      = 0;
            m_count   = 0;
        end else if (!m_active) begin
            if (start) begin
                q.delete();
                for (int k = 0; k < NREG; k++) begin
                    if (reg_list[k]) q.push_back(k);
                end
                m_wb_owed = wb_en;
`ifdef WB_SUPPRESS_IN_LIST_EN
                if (is_load && int'(rn) < NREG && reg_list[rn[2:0]]) m_wb_owed = 1'b0;
`endif
                m_is_load = is_load;
                m_rn      = int'(rn);
                m_count   = $countones(reg_list);
                m_active  = 1'b1;
            end
        end else if (q.size() > 0) begin
            if (step) void'(q.pop_front());
        end else if (m_wb_owed) begin
            m_wb_owed = 1'b0;
        end else begin
            m_active = 1'b0;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        bit e_xv, e_wb, e_done, e_en;
        int e_addr, e_waddr;
        e_xv   = m_active && (q.size() > 0);
        e_wb   = m_active && (q.size() == 0) && m_wb_owed;
        e_done = m_active && (q.size() == 0) && !m_wb_owed;
        e_addr = e_xv ? q[0] : 0;
        e_en   = (e_xv && m_is_load && step) || e_wb;
        if (e_xv)      e_waddr = e_addr;
        else if (e_wb) e_waddr = m_rn;
        else if (w_reg_addr_src == 3'd0) e_waddr = int'(addr_d);
        else if (w_reg_addr_src == 3'd1) e_waddr = int'(addr_t);
        else if (w_reg_addr_src == 3'd3) e_waddr = int'(addr_n);
        else e_waddr = 0;
        checkOutput("m_xfer_valid", int'(xfer_valid), int'(e_xv));
        checkOutput("m_xfer_addr", int'(xfer_addr), e_addr);
        checkOutput("m_xfer_last", int'(xfer_last), int'(e_xv && q.size() == 1));
        checkOutput("m_wb_valid", int'(wb_valid), int'(e_wb));
        checkOutput("m_done", int'(done), int'(e_done));
        checkOutput("m_busy", int'(busy), int'(m_active));
        checkOutput("m_w_reg_en", int'(w_reg_en_multi), int'(e_en));
        checkOutput("m_w_reg_addr", int'(w_reg_addr), e_waddr);
        checkOutput("m_reg_count", int'(reg_count), m_count);
    end

    // Inputs change 1 time unit after the falling edge, away from both edges.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit ld, input bit wb, input logic [NREG-1:0] lst,
                                 input logic [AW-1:0] r, input bit stp);
        is_load  = ld;
        wb_en    = wb;
        reg_list = lst;
        rn       = r;
        step     = stp;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    initial begin
        int exp_a2[5];
        bit pat2[5];
        exp_a2 = '{1, 1, 4, 4, 4};
        pat2   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        cyc();
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_count", int'(reg_count), 0);
        rst_n = 1'b1;
        cyc();

        // LDM 0xA5, step held high
        applyStimulus(1'b1, 1'b0, 8'hA5, 4'd0, 1'b1);
        checkOutput("t1_addr0", int'(xfer_addr), 0);
        checkOutput("t1_en0", int'(w_reg_en_multi), 1);
        cyc();
        checkOutput("t1_addr2", int'(xfer_addr), 2);
        cyc();
        checkOutput("t1_addr5", int'(xfer_addr), 5);
        checkOutput("t1_notlast", int'(xfer_last), 0);
        cyc();
        checkOutput("t1_addr7", int'(xfer_addr), 7);
        checkOutput("t1_last", int'(xfer_last), 1);
        cyc();
        checkOutput("t1_done", int'(done), 1);
        checkOutput("t1_count", int'(reg_count), 4);
        cyc();
        checkOutput("t1_idle", int'(busy), 0);

        // STM 0x12 with a stalling step pattern
        applyStimulus(1'b0, 1'b0, 8'h12, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step = pat2[i];
            checkOutput("t2_addr", int'(xfer_addr), exp_a2[i]);
            checkOutput("t2_en", int'(w_reg_en_multi), 0);
            cyc();
        end
        checkOutput("t2_done", int'(done), 1);
        step = 1'b0;
        cyc();

        // LDM 0x06 with writeback to r3
        applyStimulus(1'b1, 1'b1, 8'h06, 4'd3, 1'b1);
        checkOutput("t3_addr1", int'(xfer_addr), 1);
        cyc();
        checkOutput("t3_addr2", int'(xfer_addr), 2);
        cyc();
        checkOutput("t3_wb", int'(wb_valid), 1);
        checkOutput("t3_wb_addr", int'(w_reg_addr), 3);
        checkOutput("t3_wb_en", int'(w_reg_en_multi), 1);
        cyc();
        checkOutput("t3_done", int'(done), 1);
        cyc();

        // Same list with rn inside the list
        applyStimulus(1'b1, 1'b1, 8'h06, 4'd2, 1'b1);
        cyc();
        cyc();
`ifdef WB_SUPPRESS_IN_LIST_EN
        checkOutput("t3b_wb_skipped", int'(wb_valid), 0);
        checkOutput("t3b_done", int'(done), 1);
`else
        checkOutput("t3b_wb", int'(wb_valid), 1);
        checkOutput("t3b_wb_addr", int'(w_reg_addr), 2);
`endif
        cyc();
        cyc();
        checkOutput("t3b_idle", int'(busy), 0);

        // Empty list, no writeback
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        checkOutput("t4_done", int'(done), 1);
        checkOutput("t4_en", int'(w_reg_en_multi), 0);
        cyc();

        // Start while busy is ignored
        applyStimulus(1'b0, 1'b0, 8'h80, 4'd0, 1'b0);
        reg_list = 8'h01;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        checkOutput("t4_ignore_addr", int'(xfer_addr), 7);
        checkOutput("t4_ignore_count", int'(reg_count), 1);
        step = 1'b1;
        cyc();
        checkOutput("t4_ignore_done", int'(done), 1);
        step = 1'b0;
        cyc();

        // Asynchronous reset in the middle of an 0xFF list
        w_reg_addr_src = 3'd0;
        addr_d = '0;
        applyStimulus(1'b1, 1'b1, 8'hFF, 4'd4, 1'b1);
        for (int i = 0; i < 3; i++) cyc();
        checkOutput("t5_addr3", int'(xfer_addr), 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_xv", int'(xfer_valid), 0);
        checkOutput("t5_rst_addr", int'(xfer_addr), 0);
        checkOutput("t5_rst_waddr", int'(w_reg_addr), 0);
        checkOutput("t5_rst_en", int'(w_reg_en_multi), 0);
        checkOutput("t5_rst_busy", int'(busy), 0);
        checkOutput("t5_rst_done", int'(done), 0);
        checkOutput("t5_rst_count", int'(reg_count), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        applyStimulus(1'b1, 1'b0, 8'hFF, 4'd0, 1'b0);
        checkOutput("t5_restart_addr", int'(xfer_addr), 0);
        step = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        step = 1'b0;
        checkOutput("t5_restart_idle", int'(busy), 0);

        // Pass-through address selection while idle
        addr_d = 4'd5;
        addr_t = 4'd9;
        addr_n = 4'd12;
        w_reg_addr_src = 3'd0; #1 checkOutput("t6_src0", int'(w_reg_addr), 5);
        w_reg_addr_src = 3'd1; #1 checkOutput("t6_src1", int'(w_reg_addr), 9);
        w_reg_addr_src = 3'd3; #1 checkOutput("t6_src3", int'(w_reg_addr), 12);
        w_reg_addr_src = 3'd2; #1 checkOutput("t6_src2", int'(w_reg_addr), 0);
        w_reg_addr_src = 3'd7; #1 checkOutput("t6_src7", int'(w_reg_addr), 0);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Runaway guard
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
